// File: rtl/uart_tx_dev.sv
// Memory-mapped UART transmitter: byte FIFO, programmable baud divisor, and a
// level interrupt raised when the transmitter has drained completely.
module uart_tx_dev #(
  parameter int DEPTH     = 4,
  parameter int DIV_RESET = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_STATUS = 2'd2,
    REG_DIV    = 2'd3
  } reg_sel_t;

  reg_sel_t sel;
  logic     we_data;
  logic     we_ctrl;
  logic     we_status;
  logic     we_div;

  logic        en;
  logic        ie;
  logic [15:0] divisor;
  logic [15:0] div_eff;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  state_t      state;
  logic [7:0]  shift_reg;
  logic [15:0] div_lat;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic        baud_done;
  logic        busy;

  logic unused_bits;
  assign unused_bits = ^{Addr[31:4], Addr[1:0], Din[31:16]};

  assign sel       = reg_sel_t'(Addr[3:2]);
  assign we_data   = WE && (sel == REG_DATA);
  assign we_ctrl   = WE && (sel == REG_CTRL);
  assign we_status = WE && (sel == REG_STATUS);
  assign we_div    = WE && (sel == REG_DIV);

  assign div_eff   = (divisor == 16'd0) ? 16'd1 : divisor;
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign busy      = (state != IDLE);
  assign baud_done = (baud_cnt == div_lat - 16'd1);

  // A pop happens on the edge that starts a frame: from IDLE, or chained
  // directly off the last STOP cycle so back-to-back frames have no gap.
  assign pop  = en && !empty && ((state == IDLE) || ((state == STOP) && baud_done));
  assign push = we_data && (!full || pop);

  assign IRQ = ie & empty & ~busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      divisor <= 16'(DIV_RESET);
    end else begin
      if (we_ctrl) begin
        en <= Din[0];
        ie <= Din[1];
      end
      if (we_div) begin
        divisor <= Din[15:0];
      end
    end
  end

  // NOTE: the FIFO storage has no reset; only the pointers and count define
  // which entries are valid, so clearing the array would add logic for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= Din[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (we_status) begin
        ovf <= 1'b0;
      end else if (we_data && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      shift_reg <= '0;
      div_lat   <= 16'(DIV_RESET);
      baud_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= START;
            tx        <= 1'b0;
            shift_reg <= mem[rd_ptr];
            div_lat   <= div_eff;
            baud_cnt  <= '0;
          end
        end
        START: begin
          if (baud_done) begin
            state    <= DATA;
            tx       <= shift_reg[0];
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              state     <= START;
              tx        <= 1'b0;
              shift_reg <= mem[rd_ptr];
              div_lat   <= div_eff;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns Dout and no latch is inferred.
    Dout = '0;
    case (sel)
      REG_DATA:   Dout = '0;
      REG_CTRL:   Dout = {30'd0, ie, en};
      REG_STATUS: Dout = {23'd0, 5'(count), ovf, busy, full, empty};
      REG_DIV:    Dout = {16'd0, divisor};
      default:    Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Scoreboard bench for uart_tx_dev: stimulus queues expected frames and probe
// values; a line monitor and a probe monitor pop and compare independently.
module tb_uart_tx_dev;

  localparam int DEPTH     = 4;
  localparam int DIV_RESET = 16;

  localparam logic [31:0] A_DATA   = 32'h0;
  localparam logic [31:0] A_CTRL   = 32'h4;
  localparam logic [31:0] A_STATUS = 32'h8;
  localparam logic [31:0] A_DIV    = 32'hC;

  localparam int P_DOUT = 0;
  localparam int P_IRQ  = 1;
  localparam int P_TX   = 2;

  typedef struct {
    logic [7:0] data;
    int         d;
    int         start_cyc;
    bit         b2b;
    bit         aborted;
  } frame_t;

  typedef struct {
    int          sel;
    logic [31:0] exp;
  } probe_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        tx;

  uart_tx_dev #(.DEPTH(DEPTH), .DIV_RESET(DIV_RESET)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  frame_t exp_q[$];
  probe_t probe_q[$];
  string  probe_names[$];
  logic   probe_req  = 1'b0;
  bit     mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All main-thread tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic probe(input int sel, input logic [31:0] a, input logic [31:0] exp, input string name);
    probe_q.push_back('{sel, exp});
    probe_names.push_back(name);
    Addr      = a;
    probe_req = 1'b1;
    @(posedge clk);
    #1;
    probe_req = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] data, input int d, input int start_cyc,
                            input bit b2b, input bit aborted);
    exp_q.push_back('{data, d, start_cyc, b2b, aborted});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frames();
    int n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("frames_pending", exp_q.size() + int'(mon_active), 0);
  endtask

  // Probe monitor: samples on the falling edge while a probe is requested.
  initial begin : probe_mon
    probe_t p;
    string  nm;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (probe_req) begin
        if (probe_q.size() == 0) begin
          check("probe_queue_empty", 1, 0);
        end else begin
          p  = probe_q.pop_front();
          nm = probe_names.pop_front();
          case (p.sel)
            P_IRQ:   act = {31'd0, IRQ};
            P_TX:    act = {31'd0, tx};
            default: act = Dout;
          endcase
          check(nm, act, p.exp);
        end
      end
    end
  end

  // Line monitor: a start bit pops the next expected frame, then every
  // falling-edge sample of the frame is compared against the ideal waveform.
  initial begin : tx_mon
    frame_t     e;
    int         t0;
    int         n;
    int         shape_err;
    int         last_end;
    bit         aborted;
    logic [7:0] got;
    logic [9:0] bits;
    last_end = -100;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      t0 = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_start", t0, 0);
        while (tx === 1'b0 && reset === 1'b0) @(negedge clk);
        continue;
      end
      mon_active = 1'b1;
      e         = exp_q.pop_front();
      n         = 10 * e.d;
      bits      = {1'b1, e.data, 1'b0};
      shape_err = 0;
      aborted   = 1'b0;
      got       = '0;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(negedge clk);
        if (reset !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (tx !== bits[k / e.d]) shape_err++;
        if ((k % e.d) == (e.d / 2) && (k / e.d) >= 1 && (k / e.d) <= 8) begin
          got[(k / e.d) - 1] = tx;
        end
      end
      check("frame_aborted", {31'd0, aborted}, {31'd0, e.aborted});
      check("frame_shape_errors", shape_err, 0);
      if (!aborted) begin
        check("frame_data", {24'd0, got}, {24'd0, e.data});
        last_end = t0 + n - 1;
      end
      if (e.start_cyc >= 0) check("frame_start_cycle", t0, e.start_cyc);
      if (e.b2b) check("frame_no_gap", t0, last_end - n + 1);
      mon_active = 1'b0;
    end
  end

  int prev_end;

  initial begin : main
    int e;
    int c;
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = '0;
    Din   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    probe(P_DOUT, A_STATUS, 32'h01, "reset_status");
    probe(P_DOUT, A_CTRL,   32'h00, "reset_ctrl");
    probe(P_DOUT, A_DIV,    DIV_RESET, "reset_divisor");
    probe(P_IRQ,  A_DATA,   32'h0, "reset_irq");
    probe(P_TX,   A_DATA,   32'h1, "reset_tx");

    // Single 0xA5 frame at divisor 4
    wr(A_DIV, 4);
    wr(A_CTRL, 1);
    wr(A_DATA, 32'hA5);
    e = cyc;
    push_frame(8'hA5, 4, e + 1, 1'b0, 1'b0);
    probe(P_DOUT, A_STATUS, 32'h10, "status_one_queued");
    probe(P_DOUT, A_DATA,   32'h00, "data_reads_zero");
    wait_until(e + 40);
    probe(P_DOUT, A_STATUS, 32'h05, "status_busy_last_stop_cycle");
    probe(P_DOUT, A_STATUS, 32'h01, "status_idle_after_frame");
    wait_frames();

    // Interrupt around a divisor-2 frame
    wr(A_DIV, 2);
    wr(A_CTRL, 3);
    probe(P_IRQ, A_DATA, 32'h1, "irq_idle_empty");
    wr(A_DATA, 32'h3C);
    e = cyc;
    push_frame(8'h3C, 2, e + 1, 1'b0, 1'b0);
    probe(P_IRQ, A_DATA, 32'h0, "irq_byte_queued");
    wait_until(e + 10);
    probe(P_IRQ, A_DATA, 32'h0, "irq_mid_frame");
    wait_until(e + 20);
    probe(P_IRQ, A_DATA, 32'h0, "irq_last_frame_cycle");
    probe(P_IRQ, A_DATA, 32'h1, "irq_back_in_idle");
    wr(A_CTRL, 1);
    probe(P_IRQ, A_DATA, 32'h0, "irq_ie_cleared");
    wait_frames();

    // Enable dropped mid-frame: frame completes, second byte stays queued
    wr(A_DATA, 32'h81);
    e = cyc;
    push_frame(8'h81, 2, e + 1, 1'b0, 1'b0);
    wr(A_DATA, 32'h7E);
    wr(A_CTRL, 0);
    wait_frames();
    probe(P_DOUT, A_STATUS, 32'h10, "status_en_off_retained");
    probe(P_TX,   A_DATA,   32'h1, "tx_idle_en_off");
    wr(A_CTRL, 1);
    c = cyc;
    push_frame(8'h7E, 2, c + 1, 1'b0, 1'b0);
    wait_frames();

    // Divisor written mid-frame applies from the next frame; zero means one
    wr(A_DATA, 32'h5A);
    e = cyc;
    push_frame(8'h5A, 2, e + 1, 1'b0, 1'b0);
    wr(A_DATA, 32'hC3);
    push_frame(8'hC3, 8, -1, 1'b1, 1'b0);
    wr(A_DIV, 8);
    wait_frames();
    probe(P_DOUT, A_DIV, 32'h8, "divisor_reads_8");
    wr(A_DIV, 0);
    wr(A_DATA, 32'h96);
    e = cyc;
    push_frame(8'h96, 1, e + 1, 1'b0, 1'b0);
    wr(A_DATA, 32'h69);
    push_frame(8'h69, 1, -1, 1'b1, 1'b0);
    wait_frames();
    probe(P_DOUT, A_DIV, 32'h0, "divisor_reads_0");

    // Overflow with transmitter disabled, then drain four frames
    wr(A_DIV, 3);
    wr(A_CTRL, 0);
    wr(A_DATA, 32'h11);
    wr(A_DATA, 32'h22);
    wr(A_DATA, 32'h33);
    wr(A_DATA, 32'h44);
    wr(A_DATA, 32'h55);
    probe(P_DOUT, A_STATUS, 32'h4A, "status_full_ovf");
    wr(A_STATUS, 32'hFFFF_FFFF);
    probe(P_DOUT, A_STATUS, 32'h42, "status_ovf_cleared");
    probe(P_IRQ,  A_DATA,   32'h0, "irq_ie_off");
    wr(A_CTRL, 1);
    c = cyc;
    push_frame(8'h11, 3, c + 1, 1'b0, 1'b0);
    push_frame(8'h22, 3, -1, 1'b1, 1'b0);
    push_frame(8'h33, 3, -1, 1'b1, 1'b0);
    push_frame(8'h44, 3, -1, 1'b1, 1'b0);
    wait_frames();
    probe(P_DOUT, A_STATUS, 32'h01, "status_drained");

    // Write to a full FIFO on the same edge as a pop is accepted
    wr(A_CTRL, 0);
    wr(A_DATA, 32'hA1);
    wr(A_DATA, 32'hA2);
    wr(A_DATA, 32'hA3);
    wr(A_DATA, 32'hA4);
    probe(P_DOUT, A_STATUS, 32'h42, "status_full_no_ovf");
    wr(A_CTRL, 1);
    c = cyc;
    wr(A_DATA, 32'hB5);
    push_frame(8'hA1, 3, c + 1, 1'b0, 1'b0);
    push_frame(8'hA2, 3, -1, 1'b1, 1'b0);
    push_frame(8'hA3, 3, -1, 1'b1, 1'b0);
    push_frame(8'hA4, 3, -1, 1'b1, 1'b0);
    push_frame(8'hB5, 3, -1, 1'b1, 1'b0);
    probe(P_DOUT, A_STATUS, 32'h46, "status_full_pop_accept");
    wait_frames();
    probe(P_DOUT, A_STATUS, 32'h01, "status_drained_again");

    // Reset during data bit 3, with a competing CTRL write
    wr(A_DIV, 4);
    wr(A_CTRL, 1);
    wr(A_DATA, 32'hF0);
    e = cyc;
    push_frame(8'hF0, 4, e + 1, 1'b0, 1'b1);
    wait_until(e + 18);
    reset = 1'b1;
    Addr  = A_CTRL;
    Din   = 32'h3;
    WE    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    WE    = 1'b0;
    probe(P_TX,   A_DATA,   32'h1, "tx_after_reset");
    probe(P_DOUT, A_STATUS, 32'h01, "status_after_reset");
    probe(P_DOUT, A_DIV,    DIV_RESET, "divisor_after_reset");
    probe(P_DOUT, A_CTRL,   32'h00, "ctrl_after_reset");
    probe(P_IRQ,  A_DATA,   32'h0, "irq_after_reset");
    wait_frames();
    repeat (20) @(posedge clk);
    #1;
    probe(P_TX, A_DATA, 32'h1, "tx_stays_idle");
    check("probes_pending", probe_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
